button_toggle_debouncer: RTL and testbench

//  Conditions a raw, bouncing push-button into a clean one-cycle toggle strobe.

---
 rtl/button_ctrl_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/button_toggle_debouncer.sv | 119 +++++++++++
 tb/tb_button_toggle_debouncer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/button_ctrl_pkg.sv
// Shared definitions for push-button conditioning blocks: FSM state encoding,
// board-clock debounce default and a small sizing helper.
package button_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  // 10 ms at the 50 MHz board clock
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous pad input.
// Reset value is a parameter so each pad can power up at its idle level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_toggle_debouncer.sv
// Turns a raw bouncing push-button into a one-cycle toggle strobe, a debounced
// level, optional hold-to-repeat strobes and a wrapping strobe counter.
module button_toggle_debouncer
  import button_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEFAULT,
  parameter int BUTTON_ACTIVE_LOW = 1,
  parameter int REPEAT_EN         = 0,
  parameter int REPEAT_DELAY      = 25000000,
  parameter int REPEAT_PERIOD     = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       buttonRaw,
  output logic       togglePulse,
  output logic       buttonLevel,
  output logic [7:0] pressCount
);

  localparam int CNT_WIDTH = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;
  localparam logic [CNT_WIDTH-1:0] DB_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] RD_LAST  = CNT_WIDTH'(REPEAT_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] RP_LAST  = CNT_WIDTH'(REPEAT_PERIOD - 1);
  localparam logic                 ACT_LOW  = (BUTTON_ACTIVE_LOW != 0);

  logic                 p;
  logic                 s;
  btn_state_e           state, state_next;
  logic [CNT_WIDTH-1:0] cnt, cnt_next;
  logic                 rep_phase, rep_phase_next;
  logic                 pulse_next;

  assign p = buttonRaw ^ ACT_LOW;

  sync_2ff #(
    .RESET_VAL(1'b0)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (p),
    .q   (s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rep_phase   <= 1'b0;
      togglePulse <= 1'b0;
      buttonLevel <= 1'b0;
      pressCount  <= '0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      rep_phase   <= rep_phase_next;
      togglePulse <= pulse_next;
      buttonLevel <= (state_next == PRESSED) || (state_next == RELEASE_WAIT);
      pressCount  <= pressCount + {7'd0, pulse_next};
    end
  end

  // rep_phase selects the repeat interval: first delay after entering PRESSED, period afterwards
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    rep_phase_next = rep_phase;
    pulse_next     = 1'b0;
    case (state)
      IDLE: begin
        if (s) begin
          state_next = PRESS_WAIT;
          cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_next = IDLE;
        end else if (cnt == DB_LAST) begin
          state_next     = PRESSED;
          pulse_next     = 1'b1;
          cnt_next       = '0;
          rep_phase_next = 1'b0;
        end else begin
          cnt_next = cnt + CNT_WIDTH'(1);
        end
      end
      PRESSED: begin
        if (!s) begin
          state_next = RELEASE_WAIT;
          cnt_next   = '0;
        end else if (REPEAT_EN != 0) begin
          if (cnt == (rep_phase ? RP_LAST : RD_LAST)) begin
            pulse_next     = 1'b1;
            cnt_next       = '0;
            rep_phase_next = 1'b1;
          end else begin
            cnt_next = cnt + CNT_WIDTH'(1);
          end
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_next     = PRESSED;
          cnt_next       = '0;
          rep_phase_next = 1'b0;
        end else if (cnt == DB_LAST) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_button_toggle_debouncer.sv
// Bench for button_toggle_debouncer: one instance without and one with repeat,
// both driven by the same button and checked against a run-length reference model.
module tb_button_toggle_debouncer;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       buttonRaw;
  logic       a_pulse, a_level, r_pulse, r_level;
  logic [7:0] a_count, r_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  button_toggle_debouncer #(
    .DEBOUNCE_CYCLES(DB), .BUTTON_ACTIVE_LOW(1), .REPEAT_EN(0),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_a (
    .clk(clk), .rst(rst_n), .buttonRaw(buttonRaw),
    .togglePulse(a_pulse), .buttonLevel(a_level), .pressCount(a_count)
  );

  button_toggle_debouncer #(
    .DEBOUNCE_CYCLES(DB), .BUTTON_ACTIVE_LOW(1), .REPEAT_EN(1),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_r (
    .clk(clk), .rst(rst_n), .buttonRaw(buttonRaw),
    .togglePulse(r_pulse), .buttonLevel(r_level), .pressCount(r_count)
  );

  // Reference: level flips once the synchronized input has disagreed with it for
  // DB+1 consecutive edges; repeats fire at RD, RD+RP, ... edges of uninterrupted hold.
  typedef struct {
    bit       s1, s2;
    bit       level;
    int       run;
    int       h;
    bit       pulse;
    bit [7:0] count;
  } mdl_t;

  mdl_t ma, mr;

  function automatic void mdl_reset(output mdl_t m);
    m.s1 = 0; m.s2 = 0; m.level = 0; m.run = 0; m.h = 0; m.pulse = 0; m.count = 0;
  endfunction

  function automatic void mdl_step(inout mdl_t m, input bit p, input bit rep);
    bit s;
    s = m.s2;
    m.s2 = m.s1;
    m.s1 = p;
    m.pulse = 0;
    if (s != m.level) begin
      m.run++;
      if (m.run == DB + 1) begin
        m.level = s;
        m.run = 0;
        m.h = 0;
        if (s) begin
          m.pulse = 1;
          m.count++;
        end
      end
    end else begin
      if (m.level && rep) begin
        if (m.run > 0) m.h = 0;
        else begin
          m.h++;
          if (m.h >= RD && ((m.h - RD) % RP) == 0) begin
            m.pulse = 1;
            m.count++;
          end
        end
      end
      m.run = 0;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input bit raw);
    buttonRaw = raw;
    @(posedge clk);
    mdl_step(ma, ~raw, 1'b0);
    mdl_step(mr, ~raw, 1'b1);
    #1;
    chk("a_pulse", {31'd0, a_pulse}, ma.pulse);
    chk("a_level", {31'd0, a_level}, ma.level);
    chk("a_count", {24'd0, a_count}, ma.count);
    chk("r_pulse", {31'd0, r_pulse}, mr.pulse);
    chk("r_level", {31'd0, r_level}, mr.level);
    chk("r_count", {24'd0, r_count}, mr.count);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mdl_reset(ma);
    mdl_reset(mr);
    #1;
    chk("rst_a_pulse", {31'd0, a_pulse}, 0);
    chk("rst_a_level", {31'd0, a_level}, 0);
    chk("rst_a_count", {24'd0, a_count}, 0);
    chk("rst_r_count", {24'd0, r_count}, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1);
  endtask

  typedef struct {
    bit       raw;
    bit       pulse;
    bit       level;
    bit [7:0] count;
  } vec_t;

  vec_t tbl[34];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int       npulse, first_idx, prev;
    bit       lvl_ok;
    int       exp_rep[$];
    int       got_rep[$];

    // Clean press, release, then a bounce that never stays stable long enough
    for (int i = 0; i < 34; i++) begin
      tbl[i].raw   = (i < 9) ? 1'b0 : (i < 18) ? 1'b1 : (i < 21) ? 1'b0 :
                     (i == 21) ? 1'b1 : (i < 24) ? 1'b0 : 1'b1;
      tbl[i].pulse = (i == 6);
      tbl[i].level = (i >= 6 && i < 15);
      tbl[i].count = (i >= 6) ? 8'd1 : 8'd0;
    end

    buttonRaw = 1'b1;
    rst_n = 1'b0;
    mdl_reset(ma);
    mdl_reset(mr);
    do_reset();
    idle(4);

    for (int i = 0; i < 34; i++) begin
      tick(tbl[i].raw);
      chk($sformatf("tbl_pulse[%0d]", i), {31'd0, a_pulse}, tbl[i].pulse);
      chk($sformatf("tbl_level[%0d]", i), {31'd0, a_level}, tbl[i].level);
      chk($sformatf("tbl_count[%0d]", i), {24'd0, a_count}, tbl[i].count);
    end

    // Release bounce from PRESSED
    for (int i = 0; i < 8; i++) tick(1'b0);
    npulse = 0;
    lvl_ok = 1;
    for (int i = 0; i < 10; i++) begin
      tick(i < 2);
      if (a_pulse) npulse++;
      if (!a_level) lvl_ok = 0;
    end
    chk("relbounce_pulses", npulse, 0);
    chk("relbounce_level_held", {31'd0, lvl_ok}, 1);
    chk("relbounce_count", {24'd0, a_count}, 2);
    idle(10);

    // Hold-to-repeat on the repeat instance
    do_reset();
    idle(3);
    exp_rep = '{6, 16, 19, 22, 25, 28, 31, 34, 37};
    for (int i = 0; i < 40; i++) begin
      tick(1'b0);
      if (r_pulse) got_rep.push_back(i);
    end
    chk("repeat_npulses", got_rep.size(), exp_rep.size());
    for (int i = 0; i < exp_rep.size() && i < got_rep.size(); i++)
      chk($sformatf("repeat_edge[%0d]", i), got_rep[i], exp_rep[i]);
    chk("repeat_count", {24'd0, r_count}, 9);
    chk("repeat_a_count", {24'd0, a_count}, 1);
    idle(10);

    // Reset in PRESS_WAIT with cnt==2, button kept held
    do_reset();
    idle(3);
    for (int i = 0; i < 5; i++) tick(1'b0);
    rst_n = 1'b0;
    mdl_reset(ma);
    mdl_reset(mr);
    #1;
    chk("midrst_pulse", {31'd0, a_pulse}, 0);
    chk("midrst_level", {31'd0, a_level}, 0);
    chk("midrst_count", {24'd0, a_count}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    npulse = 0;
    first_idx = -1;
    for (int i = 0; i < 15; i++) begin
      tick(1'b0);
      if (a_pulse) begin
        npulse++;
        if (first_idx < 0) first_idx = i;
      end
    end
    chk("midrst_npulses", npulse, 1);
    chk("midrst_pulse_edge", first_idx, 6);
    idle(10);

    // 256 clean presses wrap the counter back to 0
    do_reset();
    idle(3);
    prev = 0;
    npulse = 0;
    for (int k = 0; k < 256; k++) begin
      for (int i = 0; i < 16; i++) begin
        tick(i < 8);
        if (a_pulse && prev != 0) npulse++;
        prev = a_pulse;
      end
      if (k == 254) chk("wrap_count_255", {24'd0, a_count}, 255);
    end
    chk("wrap_consecutive_pulses", npulse, 0);
    chk("wrap_count_0", {24'd0, a_count}, 0);

    // Random bursts against the reference model
    for (int k = 0; k < 200; k++) begin
      bit raw;
      int len;
      raw = 1'($urandom_range(1, 0));
      len = int'($urandom_range(12, 1));
      for (int i = 0; i < len; i++) tick(raw);
    end
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
